// File: rtl/z80_bus_monitor.sv
// Passive Z80 bus observer: classifies each bus transaction, keeps saturating
// per-class counters and a circular trace of opcode-fetch addresses, and flags
// end of run on fetch past END_ADDR, a sustained HALT, or a fetch watchdog.
module z80_bus_monitor #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] END_ADDR    = ADDR_W'('h0050),
  parameter int                CNT_W       = 32,
  parameter int                TRACE_DEPTH = 16,
  parameter int                TIMEOUT     = 1024,
  localparam int               IDX_W       = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] data_out,
  input  logic              M1_L,
  input  logic              MREQ_L,
  input  logic              IORQ_L,
  input  logic              RD_L,
  input  logic              WR_L,
  input  logic              RFSH_L,
  input  logic              HALT_L,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  mem_rd_cnt,
  output logic [CNT_W-1:0]  mem_wr_cnt,
  output logic [CNT_W-1:0]  io_cnt,
  output logic [ADDR_W-1:0] last_pc,
  output logic [DATA_W-1:0] last_wr_data,
  input  logic [IDX_W-1:0]  trace_idx,
  output logic [ADDR_W-1:0] trace_addr,
  output logic              trace_valid
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_DONE_END = 3'd2;
  localparam logic [2:0] S_HALTED   = 3'd3;
  localparam logic [2:0] S_TMO      = 3'd4;

  // Watchdog only needs to reach TIMEOUT-1; at that value the next idle edge fires.
  localparam int               WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = (TIMEOUT < 1) ? '0 : WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W:0]   DEPTH   = (IDX_W+1)'(TRACE_DEPTH);

  logic [2:0]        r_state, w_nstate;
  logic [1:0]        r_status, w_nstatus;
  logic              r_done;
  logic              r_prev_act, r_halt_prev;
  logic [WD_W-1:0]   r_wd;
  logic [CNT_W-1:0]  r_fetch_cnt, r_mem_rd_cnt, r_mem_wr_cnt, r_io_cnt;
  logic [ADDR_W-1:0] r_last_pc;
  logic [DATA_W-1:0] r_last_wr_data;
  logic [IDX_W-1:0]  r_wptr;
  logic [IDX_W:0]    r_nent;
  logic [ADDR_W-1:0] r_buf [TRACE_DEPTH];

  logic w_act, w_start, w_fetch, w_mem_rd, w_mem_wr, w_io, w_wd_fire;
  logic [IDX_W-1:0] w_rd_idx;

  // A transaction is counted once, on the first cycle its strobes are seen;
  // refresh (no RD/WR) and interrupt acknowledge (no RD/WR) never qualify.
  assign w_act    = (!MREQ_L || !IORQ_L) && (!RD_L || !WR_L);
  assign w_start  = w_act && !r_prev_act;
  assign w_fetch  = w_start && !M1_L && !MREQ_L && !RD_L;
  assign w_mem_rd = w_start &&  M1_L && !MREQ_L && !RD_L;
  assign w_mem_wr = w_start && !MREQ_L && !WR_L;
  assign w_io     = w_start && !IORQ_L && (!RD_L || !WR_L);

  // A fetch in the firing cycle resets the watchdog instead of tripping it.
  assign w_wd_fire = (TIMEOUT != 0) && !w_fetch && (r_wd == WD_LAST);

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign w_rd_idx    = r_wptr - IDX_W'(1) - trace_idx;
  assign trace_addr  = r_buf[w_rd_idx];
  assign trace_valid = ({1'b0, trace_idx} < r_nent);

  assign done         = r_done;
  assign status       = r_status;
  assign fetch_cnt    = r_fetch_cnt;
  assign mem_rd_cnt   = r_mem_rd_cnt;
  assign mem_wr_cnt   = r_mem_wr_cnt;
  assign io_cnt       = r_io_cnt;
  assign last_pc      = r_last_pc;
  assign last_wr_data = r_last_wr_data;

  // Next-state: end address beats HALT beats watchdog; terminal states hold.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: if (w_fetch) w_nstate = S_RUN;
      S_RUN: begin
        if (w_fetch && (addr_bus > END_ADDR)) w_nstate = S_DONE_END;
        else if (!HALT_L && r_halt_prev)      w_nstate = S_HALTED;
        else if (w_wd_fire)                   w_nstate = S_TMO;
      end
      default: w_nstate = r_state;
    endcase
  end

  // Status encoding of the next state, so status/done update on the same edge.
  always_comb begin
    w_nstatus = 2'b00;
    case (w_nstate)
      S_DONE_END: w_nstatus = 2'b01;
      S_HALTED:   w_nstatus = 2'b10;
      S_TMO:      w_nstatus = 2'b11;
      default:    w_nstatus = 2'b00;
    endcase
  end

  // State, registered status/done, start-edge and HALT history, watchdog.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state     <= S_IDLE;
      r_status    <= 2'b00;
      r_done      <= 1'b0;
      r_prev_act  <= 1'b0;
      r_halt_prev <= 1'b0;
      r_wd        <= '0;
    end else begin
      r_state     <= w_nstate;
      r_status    <= w_nstatus;
      r_done      <= |w_nstatus;
      r_prev_act  <= w_act;
      r_halt_prev <= !HALT_L;
      if (w_fetch)
        r_wd <= '0;
      else if (r_state == S_RUN && r_wd != WD_LAST)
        r_wd <= r_wd + WD_W'(1);
    end
  end

  // Saturating event counters and last-seen values; these keep running after done.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_fetch_cnt    <= '0;
      r_mem_rd_cnt   <= '0;
      r_mem_wr_cnt   <= '0;
      r_io_cnt       <= '0;
      r_last_pc      <= '0;
      r_last_wr_data <= '0;
    end else begin
      if (w_fetch  && r_fetch_cnt  != CNT_MAX) r_fetch_cnt  <= r_fetch_cnt  + CNT_W'(1);
      if (w_mem_rd && r_mem_rd_cnt != CNT_MAX) r_mem_rd_cnt <= r_mem_rd_cnt + CNT_W'(1);
      if (w_mem_wr && r_mem_wr_cnt != CNT_MAX) r_mem_wr_cnt <= r_mem_wr_cnt + CNT_W'(1);
      if (w_io     && r_io_cnt     != CNT_MAX) r_io_cnt     <= r_io_cnt     + CNT_W'(1);
      if (w_fetch)  r_last_pc      <= addr_bus;
      if (w_mem_wr) r_last_wr_data <= data_out;
    end
  end

  // Trace write pointer and saturating entry count.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_wptr <= '0;
      r_nent <= '0;
    end else if (w_fetch) begin
      r_wptr <= r_wptr + IDX_W'(1);
      if (r_nent != DEPTH) r_nent <= r_nent + (IDX_W+1)'(1);
    end
  end

  // Trace storage; contents are masked by trace_valid after reset.
  always_ff @(posedge clk) begin
    if (w_fetch) r_buf[r_wptr] <= addr_bus;
  end

endmodule

// File: tb/tb_z80_bus_monitor.sv
// Bench for z80_bus_monitor: directed scenarios plus randomized bus traffic,
// every cycle compared against a transaction-level reference model.
module tb_z80_bus_monitor;

  localparam int          AW = 16;
  localparam int          DW = 8;
  localparam int          CW = 4;
  localparam int          TD = 4;
  localparam int          TO = 8;
  localparam int          IW = 2;
  localparam logic [15:0] EA = 16'h0050;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_L = 1'b0;
  logic [AW-1:0] addr_bus = '0;
  logic [DW-1:0] data_out = '0;
  logic M1_L = 1'b1, MREQ_L = 1'b1, IORQ_L = 1'b1, RD_L = 1'b1, WR_L = 1'b1;
  logic RFSH_L = 1'b1, HALT_L = 1'b1;
  logic          done;
  logic [1:0]    status;
  logic [CW-1:0] fetch_cnt, mem_rd_cnt, mem_wr_cnt, io_cnt;
  logic [AW-1:0] last_pc;
  logic [DW-1:0] last_wr_data;
  logic [IW-1:0] trace_idx = '0;
  logic [AW-1:0] trace_addr;
  logic          trace_valid;

  z80_bus_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .END_ADDR(EA), .CNT_W(CW),
    .TRACE_DEPTH(TD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_out(data_out),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .RFSH_L(RFSH_L), .HALT_L(HALT_L), .done(done), .status(status),
    .fetch_cnt(fetch_cnt), .mem_rd_cnt(mem_rd_cnt), .mem_wr_cnt(mem_wr_cnt),
    .io_cnt(io_cnt), .last_pc(last_pc), .last_wr_data(last_wr_data),
    .trace_idx(trace_idx), .trace_addr(trace_addr), .trace_valid(trace_valid)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: counts, last values, newest-first fetch list, run outcome.
  int          m_fc, m_rc, m_wc, m_ic;
  logic [15:0] m_pc;
  logic [7:0]  m_wd;
  logic [15:0] m_tr[$];
  bit          m_prev, m_started, m_done;
  logic [1:0]  m_st;
  int          m_hrun, m_cyc, m_lastf;
  logic        g_halt = 1'b1;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_reset();
    m_fc = 0; m_rc = 0; m_wc = 0; m_ic = 0; m_pc = 0; m_wd = 0;
    m_tr.delete(); m_prev = 0; m_started = 0; m_done = 0; m_st = 0;
    m_hrun = 0; m_cyc = 0; m_lastf = 0;
  endtask

  task automatic model_step();
    bit act, start, f, mr, mw, io;
    act   = (!MREQ_L || !IORQ_L) && (!RD_L || !WR_L);
    start = act && !m_prev;
    m_prev = act;
    f  = start && !M1_L && !MREQ_L && !RD_L;
    mr = start &&  M1_L && !MREQ_L && !RD_L;
    mw = start && !MREQ_L && !WR_L;
    io = start && !IORQ_L && (!RD_L || !WR_L);
    m_hrun = HALT_L ? 0 : m_hrun + 1;
    m_cyc++;
    if (f)  begin m_fc = sat(m_fc); m_pc = addr_bus; m_tr.push_front(addr_bus);
                  if (m_tr.size() > TD) void'(m_tr.pop_back()); end
    if (mr) m_rc = sat(m_rc);
    if (mw) begin m_wc = sat(m_wc); m_wd = data_out; end
    if (io) m_ic = sat(m_ic);
    if (!m_done) begin
      if (!m_started) begin
        if (f) begin m_started = 1; m_lastf = m_cyc; end
      end else begin
        if (f && addr_bus > EA)              begin m_done = 1; m_st = 2'b01; end
        else if (m_hrun >= 2)                begin m_done = 1; m_st = 2'b10; end
        else if (!f && m_cyc - m_lastf == TO) begin m_done = 1; m_st = 2'b11; end
        if (f) m_lastf = m_cyc;
      end
    end
  endtask

  task automatic chk_all();
    chk("done", done, m_done);
    chk("status", status, m_st);
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("mem_rd_cnt", mem_rd_cnt, m_rc);
    chk("mem_wr_cnt", mem_wr_cnt, m_wc);
    chk("io_cnt", io_cnt, m_ic);
    chk("last_pc", last_pc, m_pc);
    chk("last_wr_data", last_wr_data, m_wd);
    for (int i = 0; i < TD; i++) begin
      trace_idx = IW'(i);
      #1;
      chk($sformatf("trace_valid[%0d]", i), trace_valid, (i < m_tr.size()));
      if (i < m_tr.size()) chk($sformatf("trace_addr[%0d]", i), trace_addr, m_tr[i]);
    end
  endtask

  // One bus cycle: drive on the falling edge, model and compare after the rising edge.
  task automatic tick(input logic m1, mreq, iorq, rd, wr, rfsh,
                      input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    M1_L = m1; MREQ_L = mreq; IORQ_L = iorq; RD_L = rd; WR_L = wr; RFSH_L = rfsh;
    addr_bus = a; data_out = d; HALT_L = g_halt;
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 1, 1, 1, 1, addr_bus, 8'h00);
  endtask
  task automatic fetch(input logic [15:0] a);
    tick(0, 0, 1, 0, 1, 1, a, 8'h00);
    tick(0, 0, 1, 0, 1, 1, a, 8'h00);
    tick(1, 0, 1, 1, 1, 0, 16'h0077, 8'h00);   // refresh
  endtask
  task automatic mem_rd(input logic [15:0] a);
    tick(1, 0, 1, 0, 1, 1, a, 8'h00); tick(1, 0, 1, 0, 1, 1, a, 8'h00);
  endtask
  task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
    tick(1, 0, 1, 1, 0, 1, a, d); tick(1, 0, 1, 1, 0, 1, a, d);
  endtask
  task automatic io_acc(input logic [15:0] a, input logic is_wr, input logic [7:0] d);
    tick(1, 1, 0, is_wr, !is_wr, 1, a, d); tick(1, 1, 0, is_wr, !is_wr, 1, a, d);
  endtask
  task automatic int_ack();
    tick(0, 1, 0, 1, 1, 1, 16'h0000, 8'h00); tick(0, 1, 0, 1, 1, 1, 16'h0000, 8'h00);
  endtask

  // Reset may be entered at any point in a cycle; outputs must clear at once.
  task automatic do_reset();
    rst_L = 1'b0;
    #1;
    model_reset();
    chk_all();
    @(negedge clk);
    M1_L = 1; MREQ_L = 1; IORQ_L = 1; RD_L = 1; WR_L = 1; RFSH_L = 1; HALT_L = 1;
    g_halt = 1'b1;
    @(negedge clk);
    rst_L = 1'b1;
  endtask

  initial begin
    int k;
    do_reset();

    // Three fetches with refresh between; trace newest-first, idx 3 empty.
    fetch(16'h0000); fetch(16'h0001); fetch(16'h0002);
    chk("t1_fetch_cnt", fetch_cnt, 3);
    chk("t1_mem_rd_cnt", mem_rd_cnt, 0);
    chk("t1_last_pc", last_pc, 16'h0002);
    trace_idx = 2'd3; #1;
    chk("t1_trace_valid3", trace_valid, 0);
    trace_idx = 2'd2; #1;
    chk("t1_trace2", trace_addr, 16'h0000);

    // Memory write, io read, interrupt acknowledge.
    do_reset();
    fetch(16'h0003);
    mem_wr(16'h1234, 8'hA5); idle(1);
    io_acc(16'h0010, 1'b0, 8'h00); idle(1);
    int_ack(); idle(1);
    chk("t2_mem_wr_cnt", mem_wr_cnt, 1);
    chk("t2_last_wr_data", last_wr_data, 8'hA5);
    chk("t2_io_cnt", io_cnt, 1);
    chk("t2_mem_rd_cnt", mem_rd_cnt, 0);

    // Walk past END_ADDR.
    do_reset();
    fetch(16'h004E); fetch(16'h004F); fetch(16'h0050);
    chk("t3_done_before", done, 0);
    fetch(16'h0051);
    chk("t3_done", done, 1);
    chk("t3_status", status, 2'b01);
    chk("t3_fetch_cnt", fetch_cnt, 4);

    // HALT one cycle is ignored, two cycles ends the run.
    do_reset();
    fetch(16'h0000);
    g_halt = 1'b0; idle(1);
    g_halt = 1'b1; idle(1);
    chk("t4_no_done", done, 0);
    g_halt = 1'b0; idle(2); g_halt = 1'b1;
    chk("t4_done", done, 1);
    chk("t4_status", status, 2'b10);

    // Watchdog: done exactly TO edges after the fetch edge.
    do_reset();
    tick(0, 0, 1, 0, 1, 1, 16'h0010, 8'h00);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      idle(1);
      if (done && k == 0) k = i;
    end
    chk("t5_wd_latency", k, TO);
    chk("t5_status", status, 2'b11);

    // END and HALT on the same edge: END wins.
    do_reset();
    fetch(16'h0000);
    g_halt = 1'b0; idle(1);
    tick(0, 0, 1, 0, 1, 1, 16'h0051, 8'h00);
    g_halt = 1'b1;
    chk("t5b_status", status, 2'b01);

    // Trace wraps over the oldest entries.
    do_reset();
    for (int i = 0; i < 6; i++) fetch(16'(i));
    for (int i = 0; i < TD; i++) begin
      trace_idx = IW'(i); #1;
      chk($sformatf("t6_trace%0d", i), trace_addr, 16'(5 - i));
    end

    // Reset in the middle of a write cycle, then count restarts at 1.
    @(negedge clk);
    M1_L = 1; MREQ_L = 0; IORQ_L = 1; RD_L = 1; WR_L = 0; addr_bus = 16'h2000; data_out = 8'h3C;
    #3;
    do_reset();
    chk("t6_rst_fetch_cnt", fetch_cnt, 0);
    chk("t6_rst_last_pc", last_pc, 0);
    fetch(16'h0020);
    chk("t6_fetch_after_rst", fetch_cnt, 1);

    // Randomized traffic, with periodic resets to reopen the run.
    do_reset();
    for (int n = 0; n < 1200; n++) begin
      logic [15:0] a;
      if (n % 150 == 149) do_reset();
      g_halt = ($urandom_range(0, 24) != 0);
      a = ($urandom_range(0, 30) == 0) ? 16'($urandom_range(16'h0051, 16'hFFFF))
                                       : 16'($urandom_range(0, 16'h0050));
      case ($urandom_range(0, 9))
        0, 1, 2: fetch(a);
        3:       mem_rd(16'($urandom));
        4:       mem_wr(16'($urandom), 8'($urandom));
        5:       io_acc(16'($urandom), 1'($urandom), 8'($urandom));
        6:       int_ack();
        7:       tick(1, 0, 1, 1, 1, 0, a, 8'h00);
        8:       tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), a, 8'($urandom));
        default: idle($urandom_range(1, 3));
      endcase
    end
    g_halt = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
